// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencer for the register-file/ALU/RAM datapath: fetch, decode and step
// addi/add/sub/lw/beq/bne through FETCH/DECODE/EXEC/MEM; any other encoding traps.
module multicycle_ctrl #(
   parameter int unsigned           DATA_WIDTH = 32,
   parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   output logic                  instr_req,
   output logic [DATA_WIDTH-1:0] instr_addr,
   input  logic                  instr_valid,
   input  logic [31:0]           instr,
   output logic                  mem_req,
   input  logic                  mem_valid,
   input  logic                  EQ,
   output logic                  ALUsrc,
   output logic [2:0]            ALUctrl,
   output logic                  RegWriteSrc,
   output logic                  RegWrite,
   output logic [4:0]            rs1,
   output logic [4:0]            rs2,
   output logic [4:0]            rd,
   output logic [DATA_WIDTH-1:0] ImmOp,
   output logic [DATA_WIDTH-1:0] pc,
   output logic [31:0]           retired,
   output logic                  illegal
);
   localparam logic [2:0]            AluAdd = 3'b000;
   localparam logic [2:0]            AluSub = 3'b001;
   localparam logic [DATA_WIDTH-1:0] PcStep = DATA_WIDTH'(4);

   typedef enum logic [2:0] {StFetch, StDecode, StExec, StMem, StTrap} state_e;
   typedef enum logic [2:0] {OpIllegal, OpAddi, OpAdd, OpSub, OpLw, OpBeq, OpBne} op_e;

   state_e                state_q, state_d;
   logic [31:0]           ir_q, ir_d;
   logic [DATA_WIDTH-1:0] pc_q, pc_d;
   logic [DATA_WIDTH-1:0] imm_q, imm_d;
   logic [31:0]           retired_q, retired_d;

   op_e                   op;
   logic [DATA_WIDTH-1:0] imm_i, imm_b;
   logic                  rd_nz;
   logic                  fetch_req;

   assign imm_i = {{(DATA_WIDTH-12){ir_q[31]}}, ir_q[31:20]};
   assign imm_b = {{(DATA_WIDTH-13){ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
   assign rd_nz = (ir_q[11:7] != 5'd0);

   always_comb begin
      op = OpIllegal;
      case (ir_q[6:0])
         7'b0010011: begin
            if (ir_q[14:12] == 3'b000) op = OpAddi;
         end
         7'b0110011: begin
            if (ir_q[14:12] == 3'b000) begin
               if (ir_q[31:25] == 7'b0000000) op = OpAdd;
               else if (ir_q[31:25] == 7'b0100000) op = OpSub;
            end
         end
         7'b0000011: begin
            if (ir_q[14:12] == 3'b010) op = OpLw;
         end
         7'b1100011: begin
            if (ir_q[14:12] == 3'b000) op = OpBeq;
            else if (ir_q[14:12] == 3'b001) op = OpBne;
         end
         default: op = OpIllegal;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      ir_d        = ir_q;
      pc_d        = pc_q;
      imm_d       = imm_q;
      retired_d   = retired_q;
      fetch_req   = 1'b0;
      mem_req     = 1'b0;
      ALUsrc      = 1'b0;
      ALUctrl     = AluAdd;
      RegWriteSrc = 1'b0;
      RegWrite    = 1'b0;
      rs1         = 5'd0;
      rs2         = 5'd0;
      rd          = 5'd0;
      unique case (state_q)
         StFetch: begin
            fetch_req = 1'b1;
            if (instr_valid) begin
               ir_d    = instr;
               state_d = StDecode;
            end
         end
         StDecode: begin
            rs1     = ir_q[19:15];
            rs2     = ir_q[24:20];
            rd      = ir_q[11:7];
            imm_d   = (op == OpBeq || op == OpBne) ? imm_b : imm_i;
            state_d = (op == OpIllegal) ? StTrap : StExec;
         end
         StExec: begin
            rs1       = ir_q[19:15];
            rs2       = ir_q[24:20];
            rd        = ir_q[11:7];
            state_d   = StFetch;
            pc_d      = pc_q + PcStep;
            retired_d = retired_q + 32'd1;
            case (op)
               OpAddi: begin
                  ALUsrc   = 1'b1;
                  RegWrite = rd_nz;
               end
               OpAdd: RegWrite = rd_nz;
               OpSub: begin
                  ALUctrl  = AluSub;
                  RegWrite = rd_nz;
               end
               OpBeq, OpBne: begin
                  ALUctrl = AluSub;
                  if ((op == OpBeq && EQ) || (op == OpBne && !EQ)) pc_d = pc_q + imm_q;
               end
               OpLw: begin
                  ALUsrc    = 1'b1;
                  state_d   = StMem;
                  pc_d      = pc_q;
                  retired_d = retired_q;
               end
               default: begin
                  state_d   = StTrap;
                  pc_d      = pc_q;
                  retired_d = retired_q;
               end
            endcase
         end
         StMem: begin
            rs1         = ir_q[19:15];
            rs2         = ir_q[24:20];
            rd          = ir_q[11:7];
            mem_req     = 1'b1;
            ALUsrc      = 1'b1;
            RegWriteSrc = 1'b1;
            // The write lands on the same edge that accepts the read data.
            RegWrite    = mem_valid & rd_nz;
            if (mem_valid) begin
               pc_d      = pc_q + PcStep;
               retired_d = retired_q + 32'd1;
               state_d   = StFetch;
            end
         end
         StTrap:  state_d = StTrap;
         default: state_d = StTrap;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StFetch;
         ir_q      <= '0;
         pc_q      <= RESET_PC;
         imm_q     <= '0;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         ir_q      <= ir_d;
         pc_q      <= pc_d;
         imm_q     <= imm_d;
         retired_q <= retired_d;
      end
   end

   // Gated by rst_n so the request drops the moment reset asserts.
   assign instr_req  = fetch_req & rst_n;
   assign instr_addr = pc_q;
   assign pc         = pc_q;
   assign retired    = retired_q;
   assign illegal    = (state_q == StTrap);
   assign ImmOp      = (state_q == StTrap) ? '0 : imm_q;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: expected PC/retired pairs are queued at issue and
// popped when the instruction completes, aborts or traps.
module tb_multicycle_ctrl;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        instr_req;
   logic [31:0] instr_addr;
   logic        instr_valid;
   logic [31:0] instr;
   logic        mem_req;
   logic        mem_valid;
   logic        EQ;
   logic        ALUsrc;
   logic [2:0]  ALUctrl;
   logic        RegWriteSrc;
   logic        RegWrite;
   logic [4:0]  rs1, rs2, rd;
   logic [31:0] ImmOp;
   logic [31:0] pc;
   logic [31:0] retired;
   logic        illegal;

   int n_pass  = 0;
   int n_total = 0;

   typedef struct {
      string       tag;
      logic [31:0] pc;
      logic [31:0] ret;
   } exp_t;
   exp_t sb[$];

   multicycle_ctrl #(
      .DATA_WIDTH (32),
      .RESET_PC   (32'h0000_0000)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .instr_req   (instr_req),
      .instr_addr  (instr_addr),
      .instr_valid (instr_valid),
      .instr       (instr),
      .mem_req     (mem_req),
      .mem_valid   (mem_valid),
      .EQ          (EQ),
      .ALUsrc      (ALUsrc),
      .ALUctrl     (ALUctrl),
      .RegWriteSrc (RegWriteSrc),
      .RegWrite    (RegWrite),
      .rs1         (rs1),
      .rs2         (rs2),
      .rd          (rd),
      .ImmOp       (ImmOp),
      .pc          (pc),
      .retired     (retired),
      .illegal     (illegal)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total = n_total + 1;
      assert (obs === exp) n_pass = n_pass + 1;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Fetch w at pc at_pc and advance to EXEC (or TRAP); queue the completion state.
   task automatic issue(input string tag, input logic [31:0] w, input logic [31:0] at_pc,
                        input logic [31:0] nxt_pc, input logic [31:0] nxt_ret);
      exp_t e;
      chk({tag, "_req"}, {31'd0, instr_req}, 32'd1);
      chk({tag, "_addr"}, instr_addr, at_pc);
      e.tag = tag;
      e.pc  = nxt_pc;
      e.ret = nxt_ret;
      sb.push_back(e);
      instr_valid = 1'b1;
      instr       = w;
      step();
      instr_valid = 1'b0;
      instr       = 32'hDEAD_BEEF;
      step();
   endtask

   task automatic pop_check();
      exp_t e;
      if (sb.size() == 0) begin
         n_total = n_total + 1;
         $error("FAIL sb_underflow: observed empty queue required one entry");
      end else begin
         e = sb.pop_front();
         chk({e.tag, "_pc"}, pc, e.pc);
         chk({e.tag, "_ret"}, retired, e.ret);
      end
   endtask

   initial begin
      rst_n       = 1'b0;
      instr_valid = 1'b0;
      instr       = '0;
      mem_valid   = 1'b0;
      EQ          = 1'b0;
      @(negedge clk);
      chk("rst_req", {31'd0, instr_req}, 32'd0);
      chk("rst_pc", pc, 32'h0);
      chk("rst_ret", retired, 32'd0);
      chk("rst_ill", {31'd0, illegal}, 32'd0);
      chk("rst_rw", {31'd0, RegWrite}, 32'd0);
      chk("rst_mreq", {31'd0, mem_req}, 32'd0);
      chk("rst_ctl", {24'd0, ALUsrc, ALUctrl, RegWriteSrc, 3'd0}, 32'd0);
      chk("rst_regs", {17'd0, rs1, rs2, rd}, 32'd0);
      chk("rst_imm", ImmOp, 32'd0);
      rst_n = 1'b1;
      #1;

      // addi x1,x0,5
      issue("addi", 32'h0050_0093, 32'h0, 32'h4, 32'd1);
      chk("addi_alusrc", {31'd0, ALUsrc}, 32'd1);
      chk("addi_aluctrl", {29'd0, ALUctrl}, 32'd0);
      chk("addi_imm", ImmOp, 32'd5);
      chk("addi_rd", {27'd0, rd}, 32'd1);
      chk("addi_rw", {31'd0, RegWrite}, 32'd1);
      chk("addi_rwsrc", {31'd0, RegWriteSrc}, 32'd0);
      step();
      pop_check();

      // add x2,x1,x1 then sub x2,x1,x1
      issue("add", 32'h0010_8133, 32'h4, 32'h8, 32'd2);
      chk("add_ctl", {28'd0, ALUsrc, ALUctrl}, 32'h0);
      chk("add_rw_rd", {26'd0, RegWrite, rd}, {26'd0, 1'b1, 5'd2});
      chk("add_rs", {22'd0, rs1, rs2}, {22'd0, 5'd1, 5'd1});
      step();
      pop_check();
      issue("sub", 32'h4010_8133, 32'h8, 32'hC, 32'd3);
      chk("sub_ctl", {28'd0, ALUsrc, ALUctrl}, 32'h1);
      chk("sub_rw_rd", {26'd0, RegWrite, rd}, {26'd0, 1'b1, 5'd2});
      step();
      pop_check();

      // lw x3,0(x0) with three wait cycles
      issue("lw", 32'h0000_2183, 32'hC, 32'h10, 32'd4);
      chk("lw_exec", {28'd0, ALUsrc, RegWrite, mem_req, RegWriteSrc}, 32'b1000);
      chk("lw_imm", ImmOp, 32'd0);
      step();
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("lw_wait%0d", i), {28'd0, mem_req, RegWrite, RegWriteSrc, ALUsrc},
             32'b1011);
         step();
      end
      mem_valid = 1'b1;
      #1;
      chk("lw_done", {28'd0, mem_req, RegWrite, RegWriteSrc, ALUsrc}, 32'b1111);
      chk("lw_rd", {27'd0, rd}, 32'd3);
      step();
      mem_valid = 1'b0;
      chk("lw_back_req", {31'd0, instr_req}, 32'd1);
      pop_check();

      // bne x1,x0,-8: taken, then two nops back to 0x10, then not taken
      issue("bne_t", 32'hFE00_9CE3, 32'h10, 32'h08, 32'd5);
      EQ = 1'b0;
      #1;
      chk("bne_t_ctl", {27'd0, ALUsrc, ALUctrl, RegWrite}, 32'b0_001_0);
      chk("bne_imm", ImmOp, 32'hFFFF_FFF8);
      step();
      pop_check();
      issue("nop0", 32'h0000_0013, 32'h08, 32'h0C, 32'd6);
      chk("nop0_rw", {30'd0, ALUsrc, RegWrite}, 32'b10);
      step();
      pop_check();
      issue("nop1", 32'h0000_0013, 32'h0C, 32'h10, 32'd7);
      step();
      pop_check();
      issue("bne_n", 32'hFE00_9CE3, 32'h10, 32'h14, 32'd8);
      EQ = 1'b1;
      #1;
      chk("bne_n_rw", {31'd0, RegWrite}, 32'd0);
      step();
      EQ = 1'b0;
      pop_check();

      // Idle fetch with a stray mem_valid
      mem_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("idle%0d", i), {instr_addr[27:0], instr_req, RegWrite, mem_req, 1'b0},
             {28'h000_0014, 4'b1000});
         step();
      end
      mem_valid = 1'b0;

      // Illegal encoding traps, stray instr_valid ignored afterwards
      issue("trap", 32'hFFFF_FFFF, 32'h14, 32'h14, 32'd8);
      chk("trap_ill", {31'd0, illegal}, 32'd1);
      chk("trap_req", {31'd0, instr_req}, 32'd0);
      chk("trap_ctl", {30'd0, RegWrite, mem_req}, 32'd0);
      chk("trap_imm", ImmOp, 32'd0);
      pop_check();
      instr_valid = 1'b1;
      step();
      step();
      instr_valid = 1'b0;
      chk("trap_stay", {pc[30:0], illegal}, {31'h14 >> 0, 1'b1});

      // Reset clears the trap
      rst_n = 1'b0;
      #1;
      chk("rst2_ill", {31'd0, illegal}, 32'd0);
      chk("rst2_pc", pc, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;

      // Reset during MEM wait aborts the load with no write
      issue("lw_abort", 32'h0000_2183, 32'h0, 32'h0, 32'd0);
      step();
      chk("abort_mreq", {31'd0, mem_req}, 32'd1);
      step();
      rst_n     = 1'b0;
      mem_valid = 1'b1;
      #1;
      chk("abort_out", {26'd0, RegWrite, mem_req, instr_req, RegWriteSrc, ALUsrc, 1'b0}, 32'd0);
      chk("abort_rd", {27'd0, rd}, 32'd0);
      pop_check();
      step();
      rst_n     = 1'b1;
      mem_valid = 1'b0;
      #1;
      chk("post_rst_fetch", {instr_addr[30:0], instr_req}, 32'd1);
      chk("sb_empty", sb.size(), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
